// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - byte/half/word load-store unit over a word-addressed memory
// Optional misalignment trap: define LSU_ALIGN_CHECK_EN.
module lsu_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_write,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          lane_q, lane_d;
  logic                uns_q, uns_d;
  logic                mis_q, mis_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    addr_q, addr_d;
  logic                mem_wr;
  logic                is_word, is_half, misaligned;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_W-1:0]   ld_val, merged;
  logic                unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:IDX_W+2];
  assign is_word     = size_q[1];
  assign is_half     = (size_q == 2'b01);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = (is_half && lane_q[0]) || (is_word && (lane_q != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane extraction for loads and lane merge for sub-word stores; the
  // store data already sits in wdata_q, so the merged word overwrites it.
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_val   = mem_rdata;
    if (is_half)
      ld_val = {{16{~uns_q & half_sel[15]}}, half_sel};
    else if (!is_word)
      ld_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
    merged = mem_rdata;
    if (is_half) begin
      if (lane_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    lane_d  = lane_q;
    uns_d   = uns_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    mem_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          uns_d   = unsigned_ld;
          lane_d  = addr[1:0];
          addr_d  = addr[IDX_W+1:2];
          wdata_d = wdata;
          mis_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mis_d   = misaligned;
        state_d = DONE;
        if (!misaligned) begin
          if (!we_q) begin
            rdata_d = ld_val;
          end else if (is_word) begin
            mem_wr = 1'b1;
          end else begin
            wdata_d = merged;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_wr  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end

  // Gate with rst so a reset landing mid-store never commits a write.
  assign mem_write = mem_wr & ~rst;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = done & mis_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - randomized bench for lsu_mem_ctrl against a byte-array model
module tb_lsu_mem_ctrl;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, err, mem_write;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [16:0] mem_addr;

  logic [31:0] mem [16];
  logic        tb_wr = 1'b0;
  logic [3:0]  tb_idx = '0;
  logic [31:0] tb_dat = '0;
  int          wr_total = 0;

  logic [7:0]  rb [64];
  logic [31:0] exp_rd = '0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[3:0]] <= mem_wdata;
      wr_total <= wr_total + 1;
    end else if (tb_wr) begin
      mem[tb_idx] <= tb_dat;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rword(input int i);
    return {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
  endfunction

  task automatic set_word(input int i, input logic [31:0] v);
    @(negedge clk);
    tb_wr  = 1'b1;
    tb_idx = i[3:0];
    tb_dat = v;
    @(posedge clk);
    #1 tb_wr = 1'b0;
    for (int k = 0; k < 4; k++) rb[4*i+k] = v[8*k +: 8];
  endtask

  task automatic do_access(input bit w, input bit [1:0] sz, input bit u,
                           input bit [5:0] a, input bit [31:0] wd);
    bit          hw, wd_sz, mis, got;
    int          ea, nb, exp_lat, exp_wr, lat, wr0;
    logic [31:0] v;
    hw      = (sz == 2'b01);
    wd_sz   = sz[1];
    mis     = ALIGN && ((hw && a[0]) || (wd_sz && a[1:0] != 2'b00));
    nb      = wd_sz ? 4 : (hw ? 2 : 1);
    ea      = wd_sz ? int'(a & 6'h3c) : (hw ? int'(a & 6'h3e) : int'(a));
    exp_lat = (w && !wd_sz && !mis) ? 3 : 2;
    exp_wr  = (w && !mis) ? 1 : 0;
    if (!w && !mis) begin
      v = '0;
      for (int k = 0; k < nb; k++) v = v | (32'(rb[ea+k]) << (8*k));
      if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      exp_rd = v;
    end
    if (w && !mis)
      for (int k = 0; k < nb; k++) rb[ea+k] = wd[8*k +: 8];

    @(negedge clk);
    req = 1'b1; we = w; size = sz; unsigned_ld = u;
    addr = {26'b0, a}; wdata = wd;
    wr0 = wr_total;
    @(posedge clk);
    #1;
    req = 1'b0; we = $urandom; size = 2'($urandom); unsigned_ld = $urandom;
    addr = {26'b0, 6'($urandom)}; wdata = $urandom;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_c1", 32'(busy), 32'd1);
      if (done) begin
        got = 1'b1;
        lat = c;
        check("err", 32'(err), 32'(mis));
      end
    end
    check("latency", lat, exp_lat);
    check("rdata", rdata, exp_rd);
    check("wr_count", wr_total - wr0, exp_wr);
    check("mem_word", mem[ea >> 2], rword(ea >> 2));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    set_word(1, 32'h8899AABB);

    do_access(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);
    check("tp_word_ld", rdata, 32'h8899AABB);
    do_access(1'b0, 2'b00, 1'b0, 6'h07, 32'h0);
    check("tp_byte_sx", rdata, 32'hFFFFFF88);
    do_access(1'b0, 2'b00, 1'b1, 6'h07, 32'h0);
    check("tp_byte_zx", rdata, 32'h00000088);
    do_access(1'b1, 2'b00, 1'b0, 6'h05, 32'h000000CC);
    check("tp_byte_st", mem[1], 32'h8899CCBB);
    set_word(1, 32'h8899AABB);
    do_access(1'b1, 2'b01, 1'b0, 6'h06, 32'h00001234);
    check("tp_half_st", mem[1], 32'h1234AABB);
    do_access(1'b0, 2'b01, 1'b0, 6'h06, 32'h0);
    check("tp_half_ld", rdata, 32'h00001234);
    set_word(1, 32'h8899AABB);
    do_access(1'b0, 2'b10, 1'b0, 6'h06, 32'h0);

    for (int n = 0; n < 300; n++)
      do_access(1'($urandom), 2'($urandom), 1'($urandom), 6'($urandom), $urandom);

    // Reset landing on the WRITE cycle of a byte store.
    set_word(1, 32'h8899AABB);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'h5; wdata = 32'hCC;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_wr_gate", 32'(mem_write), 32'd0);
    @(negedge clk);
    check("rst_wr_gate_neg", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_mem", mem[1], 32'h8899AABB);
    exp_rd = '0;
    do_access(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);

    for (int i = 0; i < 16; i++) check("mem_final", mem[i], rword(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
